char_addr_gen: RTL and testbench
================================

Name: char_addr_gen

Overview:
- Sequential, parametrised successor to the fixed-geometry text-mode character address computation.
- Tracks character column/row and glyph pixel offsets from VGA timing strobes.
- Produces a registered text-buffer address per active pixel, with hardware row scrolling applied at frame boundaries.
- Sits between the VGA timing generator and the character RAM / glyph ROM lookup.

Parameters:
- COLS, 80, character columns per row.
- ROWS, 30, character rows per screen; buffer size BUF = COLS*ROWS.
- GLYPH_W, 8, glyph width in pixels (power of two).
- GLYPH_H, 16, glyph height in lines (power of two).
- ADDR_W, 15, char_addr width.
- BASE, 'h600, buffer start address added to every output.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- frame_start  in  1  one-cycle pulse before first active line of a frame
- line_start  in  1  one-cycle pulse before each active line; pix_valid low that cycle
- pix_valid  in  1  active-video pixel this cycle
- scroll_inc  in  1  pulse: request scroll by one character row
- scroll_clr  in  1  pulse: request scroll offset = 0
- cursor_col  in  clog2(COLS)  cursor column (optional feature)
- cursor_row  in  clog2(ROWS)  cursor row (optional feature)
- char_addr  out  ADDR_W  character buffer address
- glyph_x  out  clog2(GLYPH_W)  pixel column inside glyph
- glyph_y  out  clog2(GLYPH_H)  line inside glyph
- addr_valid  out  1  outputs valid this cycle
- cursor_hit  out  1  current cell is cursor cell

Behaviour:
- Reset (async, any time, including mid-frame) clears every register: all outputs 0; counters 0; pending and active scroll base 0; first_line flag 1.
- Scroll state:
  - pend_base in [0, BUF).
  - scroll_inc: pend_base += COLS; if result >= BUF, subtract BUF.
  - scroll_clr: pend_base = 0; wins over same-cycle scroll_inc.
- frame_start:
  - act_base = pend_base, including a same-cycle scroll_inc/scroll_clr update.
  - row_base = that value; col = 0, gx = 0, gy = 0, row = 0, first_line = 1.
  - Scroll never changes mid-frame.
- line_start:
  - col = 0, gx = 0.
  - If first_line: clear first_line, leave gy/row unchanged.
  - Else: gy++. On wrap from GLYPH_H-1 to 0: row++, row_base += COLS with wrap at BUF (conditional subtract, no multiplier).
- pix_valid:
  - gx++. On wrap from GLYPH_W-1: col++, saturating at COLS.
- in_range = (col < COLS) && (row < ROWS). Out-of-range pixels produce addr_valid = 0; counters keep running.
- Pipeline, 2 cycles, pix_valid in cycle N -> outputs in cycle N+2:
  - Stage 1 registers sum = row_base + col, gx, gy, in_range & pix_valid.
  - Stage 2 registers char_addr = BASE + (sum >= BUF ? sum - BUF : sum), truncated to ADDR_W; glyph_x, glyph_y; addr_valid.
  - Internal sum width is clog2(2*BUF).
- When addr_valid = 0, char_addr, glyph_x and glyph_y hold their last values.
- frame_start or line_start do not flush the pipeline; in-flight pixels complete.

Optional Feature:
- Macro: CHAR_ADDR_CURSOR_EN.
- Defined:
  - Stage 1 compares (col, row) with (cursor_col, cursor_row). Row is the screen row, independent of scroll.
  - cursor_hit is registered through stage 2, aligned with addr_valid, and is 0 whenever addr_valid = 0.
- Undefined:
  - cursor_hit tied 0; cursor inputs ignored.
  - No compare logic is synthesised.

Test Plan:
- Reset asserted mid-line with pix_valid high -> same cycle all outputs 0. After release: frame_start, line_start, one pixel -> char_addr 0x600 two cycles later.
- Frame start, line 0, 16 pixels -> addr_valid high cycles 2..17; char_addr 0x600 with glyph_x 0..7, then 0x601 with glyph_x 0..7; glyph_y 0.
- Advance 16 line_starts (line 16), first pixel -> char_addr 0x650, glyph_y 0. Line 17 -> glyph_y 1.
- scroll_inc mid-frame:
  - Current frame unchanged.
  - Next frame, row 0 -> 0x650; row 29 (line 464) -> 0x600 (wrap).
  - scroll_inc on the frame_start cycle is applied to that frame.
- Line with 650 pixels -> pixels 0..639 valid, last valid char_addr 0x64F; pixels 640..649 give addr_valid 0. Line 480 -> addr_valid 0 throughout.
- With CHAR_ADDR_CURSOR_EN, cursor (3,1) -> cursor_hit high exactly for line 16..31 pixels 24..31, aligned with addr_valid. Without the macro -> cursor_hit stays 0.

Source files
------------

// File: rtl/char_addr_gen.sv
// char_addr_gen
// Text-mode character address generator. Follows the VGA timing strobes to
// track character column/row and the pixel offset inside the glyph cell, then
// emits a registered character-buffer address per active pixel through a
// two-stage pipeline. Hardware row scrolling is latched at frame boundaries
// so that the visible picture never tears mid-frame.
//
// Optional feature: define CHAR_ADDR_CURSOR_EN to build the cursor-cell
// compare that drives cursor_hit. Without it cursor_hit is tied low and the
// cursor inputs are ignored.
module char_addr_gen #(
    parameter int unsigned COLS    = 80,
    parameter int unsigned ROWS    = 30,
    parameter int unsigned GLYPH_W = 8,
    parameter int unsigned GLYPH_H = 16,
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned BASE    = 'h600
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_start,
    input  logic                       line_start,
    input  logic                       pix_valid,
    input  logic                       scroll_inc,
    input  logic                       scroll_clr,
    input  logic [$clog2(COLS)-1:0]    cursor_col,
    input  logic [$clog2(ROWS)-1:0]    cursor_row,
    output logic [ADDR_W-1:0]          char_addr,
    output logic [$clog2(GLYPH_W)-1:0] glyph_x,
    output logic [$clog2(GLYPH_H)-1:0] glyph_y,
    output logic                       addr_valid,
    output logic                       cursor_hit
);

    // Buffer geometry and internal widths.
    localparam int unsigned BUF    = COLS * ROWS;
    localparam int unsigned SUM_W  = $clog2(2 * BUF);
    localparam int unsigned BASE_W = $clog2(BUF);
    // Column saturates at COLS and row at ROWS, so both need one extra code.
    localparam int unsigned COL_W  = $clog2(COLS + 1);
    localparam int unsigned ROW_W  = $clog2(ROWS + 1);
    localparam int unsigned GX_W   = $clog2(GLYPH_W);
    localparam int unsigned GY_W   = $clog2(GLYPH_H);

    // Advance a buffer offset by one character row, wrapping at BUF with a
    // conditional subtract instead of a modulo or multiplier.
    function automatic logic [BASE_W-1:0] add_row(input logic [BASE_W-1:0] b);
        logic [SUM_W-1:0] t;
        t = SUM_W'(b) + SUM_W'(COLS);
        if (t >= SUM_W'(BUF)) begin
            t = t - SUM_W'(BUF);
        end
        return BASE_W'(t);
    endfunction

    // ------------------------------------------------------------------
    // Scroll and position state
    // ------------------------------------------------------------------
    logic [BASE_W-1:0] pend_base_q, pend_base_d;   // scroll requested for next frame
    logic [BASE_W-1:0] row_base_q,  row_base_d;    // buffer offset of current char row
    logic [COL_W-1:0]  col_q,       col_d;
    logic [ROW_W-1:0]  row_q,       row_d;
    logic [GX_W-1:0]   gx_q,        gx_d;
    logic [GY_W-1:0]   gy_q,        gy_d;
    logic              first_line_q, first_line_d;

    // ------------------------------------------------------------------
    // Pipeline stage 1
    // ------------------------------------------------------------------
    logic [SUM_W-1:0]  s1_sum_q,   s1_sum_d;
    logic [GX_W-1:0]   s1_gx_q,    s1_gx_d;
    logic [GY_W-1:0]   s1_gy_q,    s1_gy_d;
    logic              s1_valid_q, s1_valid_d;
    logic              in_range;

    // ------------------------------------------------------------------
    // Pipeline stage 2 (outputs)
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] char_addr_q,  char_addr_d;
    logic [GX_W-1:0]   glyph_x_q,    glyph_x_d;
    logic [GY_W-1:0]   glyph_y_q,    glyph_y_d;
    logic              addr_valid_q, addr_valid_d;
    logic [SUM_W-1:0]  s1_wrapped;

    // Next-state for scroll offsets, beam position counters and first-line flag.
    always_comb begin
        // NOTE: every variable gets a hold default first so no path through
        // the branches below can leave it unassigned and infer a latch.
        pend_base_d  = pend_base_q;
        row_base_d   = row_base_q;
        col_d        = col_q;
        row_d        = row_q;
        gx_d         = gx_q;
        gy_d         = gy_q;
        first_line_d = first_line_q;

        // Clear beats increment when both arrive together.
        if (scroll_clr) begin
            pend_base_d = '0;
        end else if (scroll_inc) begin
            pend_base_d = add_row(pend_base_q);
        end

        if (frame_start) begin
            // The frame adopts the pending scroll, including an update
            // arriving on this very cycle; it is then frozen for the frame.
            row_base_d   = pend_base_d;
            col_d        = '0;
            row_d        = '0;
            gx_d         = '0;
            gy_d         = '0;
            first_line_d = 1'b1;
        end else if (line_start) begin
            col_d = '0;
            gx_d  = '0;
            if (first_line_q) begin
                // The pulse ahead of line 0 only arms the line counter.
                first_line_d = 1'b0;
            end else begin
                gy_d = gy_q + GY_W'(1);
                if (gy_q == GY_W'(GLYPH_H - 1)) begin
                    // Saturate so that lines past the last row never alias
                    // back into the visible area.
                    if (row_q != ROW_W'(ROWS)) begin
                        row_d = row_q + ROW_W'(1);
                    end
                    row_base_d = add_row(row_base_q);
                end
            end
        end else if (pix_valid) begin
            gx_d = gx_q + GX_W'(1);
            if ((gx_q == GX_W'(GLYPH_W - 1)) && (col_q != COL_W'(COLS))) begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Position and scroll registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its neighbours.
            pend_base_q  <= '0;
            row_base_q   <= '0;
            col_q        <= '0;
            row_q        <= '0;
            gx_q         <= '0;
            gy_q         <= '0;
            first_line_q <= 1'b1;
        end else begin
            pend_base_q  <= pend_base_d;
            row_base_q   <= row_base_d;
            col_q        <= col_d;
            row_q        <= row_d;
            gx_q         <= gx_d;
            gy_q         <= gy_d;
            first_line_q <= first_line_d;
        end
    end

    // Stage 1: unwrapped buffer offset and the validity of this pixel.
    always_comb begin
        in_range   = (col_q < COL_W'(COLS)) && (row_q < ROW_W'(ROWS));
        s1_sum_d   = SUM_W'(row_base_q) + SUM_W'(col_q);
        s1_gx_d    = gx_q;
        s1_gy_d    = gy_q;
        s1_valid_d = pix_valid && in_range;
    end

    // Stage 1 registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_sum_q   <= '0;
            s1_gx_q    <= '0;
            s1_gy_q    <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_sum_q   <= s1_sum_d;
            s1_gx_q    <= s1_gx_d;
            s1_gy_q    <= s1_gy_d;
            s1_valid_q <= s1_valid_d;
        end
    end

    // Stage 2: wrap into the buffer, add the base, hold data on idle cycles.
    always_comb begin
        s1_wrapped   = (s1_sum_q >= SUM_W'(BUF)) ? (s1_sum_q - SUM_W'(BUF)) : s1_sum_q;
        char_addr_d  = char_addr_q;
        glyph_x_d    = glyph_x_q;
        glyph_y_d    = glyph_y_q;
        addr_valid_d = s1_valid_q;
        if (s1_valid_q) begin
            char_addr_d = ADDR_W'(BASE) + ADDR_W'(s1_wrapped);
            glyph_x_d   = s1_gx_q;
            glyph_y_d   = s1_gy_q;
        end
    end

    // Stage 2 registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            char_addr_q  <= '0;
            glyph_x_q    <= '0;
            glyph_y_q    <= '0;
            addr_valid_q <= 1'b0;
        end else begin
            char_addr_q  <= char_addr_d;
            glyph_x_q    <= glyph_x_d;
            glyph_y_q    <= glyph_y_d;
            addr_valid_q <= addr_valid_d;
        end
    end

    assign char_addr  = char_addr_q;
    assign glyph_x    = glyph_x_q;
    assign glyph_y    = glyph_y_q;
    assign addr_valid = addr_valid_q;

`ifdef CHAR_ADDR_CURSOR_EN
    // Cursor compare uses the screen row, so it is independent of scrolling.
    logic s1_hit_q, s1_hit_d;
    logic cursor_hit_q, cursor_hit_d;

    // Stage 1 cursor compare and stage 2 alignment with addr_valid.
    always_comb begin
        s1_hit_d     = (col_q == COL_W'(cursor_col)) && (row_q == ROW_W'(cursor_row));
        cursor_hit_d = s1_valid_q && s1_hit_q;
    end

    // Cursor pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_hit_q     <= 1'b0;
            cursor_hit_q <= 1'b0;
        end else begin
            s1_hit_q     <= s1_hit_d;
            cursor_hit_q <= cursor_hit_d;
        end
    end

    assign cursor_hit = cursor_hit_q;
`else
    // Cursor feature absent: output tied low, inputs only reduced into a
    // dangling net that synthesis removes.
    logic unused_cursor;
    assign unused_cursor = ^{cursor_col, cursor_row};
    assign cursor_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_char_addr_gen.sv
// tb_char_addr_gen
// Directed bench for char_addr_gen with default parameters (80x30 cells,
// 8x16 glyphs, base 0x600). Table-driven probes of single pixels plus
// hand-written cycle-by-cycle sequences for reset, pipeline latency and the
// cursor window. Cursor expectations follow CHAR_ADDR_CURSOR_EN.
module tb_char_addr_gen;

`ifdef CHAR_ADDR_CURSOR_EN
    localparam bit CUR_EN = 1'b1;
`else
    localparam bit CUR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        line_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic        scroll_inc = 1'b0;
    logic        scroll_clr = 1'b0;
    logic [6:0]  cursor_col = 7'd3;
    logic [4:0]  cursor_row = 5'd1;
    logic [14:0] char_addr;
    logic [2:0]  glyph_x;
    logic [3:0]  glyph_y;
    logic        addr_valid;
    logic        cursor_hit;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    char_addr_gen dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .line_start  (line_start),
        .pix_valid   (pix_valid),
        .scroll_inc  (scroll_inc),
        .scroll_clr  (scroll_clr),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row),
        .char_addr   (char_addr),
        .glyph_x     (glyph_x),
        .glyph_y     (glyph_y),
        .addr_valid  (addr_valid),
        .cursor_hit  (cursor_hit)
    );

    // Probe record: scroll action, target line and pixel, expected outputs.
    // scr: 0 none, 1 inc before frame, 2 clr before frame, 3 inc on the
    // frame_start cycle, 4 inc mid-frame, 5 inc+clr together before frame,
    // 6 twenty-nine incs before frame.
    typedef struct {
        int scr;
        int line;
        int pix;
        bit valid;
        int addr;
        int gx;
        int gy;
        bit hit;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic add(input int scr, input int line, input int pix, input bit valid,
                       input int addr, input int gx, input int gy, input bit hit);
        vec_t v;
        v.scr = scr; v.line = line; v.pix = pix; v.valid = valid;
        v.addr = addr; v.gx = gx; v.gy = gy; v.hit = hit;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        frame_start = 1'b0; line_start = 1'b0; pix_valid = 1'b0;
        scroll_inc = 1'b0; scroll_clr = 1'b0;
        repeat (n) tick();
    endtask

    task automatic frame_pulse(input bit with_inc);
        frame_start = 1'b1;
        scroll_inc  = with_inc;
        tick();
        frame_start = 1'b0;
        scroll_inc  = 1'b0;
    endtask

    task automatic line_pulse();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"},  32'(char_addr),  32'h0);
        check({tag, "_gx"},    32'(glyph_x),    32'h0);
        check({tag, "_gy"},    32'(glyph_y),    32'h0);
        check({tag, "_valid"}, 32'(addr_valid), 32'h0);
        check({tag, "_hit"},   32'(cursor_hit), 32'h0);
    endtask

    // Drive one frame up to (line, pix) and leave the pixel's result on the
    // outputs, sampled on the falling edge.
    task automatic run_probe(input int scr, input int line, input int pix);
        idle(2);
        case (scr)
            1: begin scroll_inc = 1'b1; tick(); scroll_inc = 1'b0; end
            2: begin scroll_clr = 1'b1; tick(); scroll_clr = 1'b0; end
            5: begin scroll_inc = 1'b1; scroll_clr = 1'b1; tick();
                     scroll_inc = 1'b0; scroll_clr = 1'b0; end
            6: repeat (29) begin scroll_inc = 1'b1; tick(); scroll_inc = 1'b0; end
            default: ;
        endcase
        frame_pulse(scr == 3);
        for (int l = 0; l <= line; l++) begin
            line_pulse();
            if (scr == 4 && l == 0) begin
                scroll_inc = 1'b1;
                tick();
                scroll_inc = 1'b0;
            end
        end
        for (int k = 0; k <= pix; k++) begin
            pix_valid = 1'b1;
            tick();
        end
        pix_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit exp_v;
        bit exp_h;
        int k;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        #1 reset = 1'b0;
        tick();

        // ---------------- reset mid-line with pixels streaming ----------------
        frame_pulse(1'b0);
        line_pulse();
        pix_valid = 1'b1;
        repeat (12) tick();
        #3 reset = 1'b1;
        #1;
        check_all_zero("midreset");
        pix_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        idle(1);
        frame_pulse(1'b0);
        line_pulse();
        for (int c = 0; c < 4; c++) begin
            pix_valid = (c == 0);
            @(negedge clk);
            check($sformatf("postreset_valid_c%0d", c), 32'(addr_valid), 32'(c == 2));
            if (c == 2) check("postreset_addr", 32'(char_addr), 32'h600);
            tick();
        end
        pix_valid = 1'b0;

        // ---------------- first 16 pixels of line 0 ----------------
        idle(2);
        frame_pulse(1'b0);
        line_pulse();
        for (int c = 0; c < 20; c++) begin
            pix_valid = (c < 16);
            @(negedge clk);
            exp_v = (c >= 2) && (c <= 17);
            check($sformatf("line0_valid_c%0d", c), 32'(addr_valid), 32'(exp_v));
            if (exp_v) begin
                k = c - 2;
                check($sformatf("line0_addr_c%0d", c), 32'(char_addr), 32'h600 + 32'(k / 8));
                check($sformatf("line0_gx_c%0d", c),   32'(glyph_x),   32'(k % 8));
                check($sformatf("line0_gy_c%0d", c),   32'(glyph_y),   32'h0);
            end
            tick();
        end
        pix_valid = 1'b0;

        // ---------------- cursor window on line 16 ----------------
        idle(2);
        frame_pulse(1'b0);
        repeat (17) line_pulse();
        for (int c = 0; c < 42; c++) begin
            pix_valid = (c < 40);
            @(negedge clk);
            k = c - 2;
            exp_v = (c >= 2);
            exp_h = CUR_EN && exp_v && (k >= 24) && (k <= 31);
            check($sformatf("cursor_valid_c%0d", c), 32'(addr_valid), 32'(exp_v));
            check($sformatf("cursor_hit_c%0d", c),   32'(cursor_hit), 32'(exp_h));
            tick();
        end
        pix_valid = 1'b0;

        // ---------------- table of single-pixel probes ----------------
        //  scr line pix  valid addr    gx gy hit
        add(0,   0,   0, 1, 'h600, 0,  0, 0);
        add(0,   0,   7, 1, 'h600, 7,  0, 0);
        add(0,   0,   8, 1, 'h601, 0,  0, 0);
        add(0,   0,  15, 1, 'h601, 7,  0, 0);
        add(0,  16,   0, 1, 'h650, 0,  0, 0);
        add(0,  17,   3, 1, 'h650, 3,  1, 0);
        add(0,  31,   9, 1, 'h651, 1, 15, 0);
        add(0,  16,  24, 1, 'h653, 0,  0, 1);
        add(0,  31,  31, 1, 'h653, 7, 15, 1);
        add(0,  16,  32, 1, 'h654, 0,  0, 0);
        add(0,  15,  24, 1, 'h603, 0, 15, 0);
        add(0,  32,  24, 1, 'h6A3, 0,  0, 0);
        add(0,   0, 639, 1, 'h64F, 7,  0, 0);
        add(0,   0, 645, 0, 'h64F, 7,  0, 0);   // past last column: held data
        add(0, 479, 639, 1, 'hF5F, 7, 15, 0);   // last cell of the buffer
        add(0, 480,   0, 0, 'hF5F, 7, 15, 0);   // below last row: held data
        add(4,   1,   0, 1, 'h600, 0,  1, 0);   // mid-frame inc: this frame unchanged
        add(0,   0,   0, 1, 'h650, 0,  0, 0);   // next frame scrolled by one row
        add(0, 464,   0, 1, 'h600, 0,  0, 0);   // row 29 wraps to buffer start
        add(0, 448,   0, 1, 'hF10, 0,  0, 0);
        add(3,   0,   0, 1, 'h6A0, 0,  0, 0);   // inc on frame_start applies now
        add(2,   0,   0, 1, 'h600, 0,  0, 0);   // clear
        add(1,   0,   0, 1, 'h650, 0,  0, 0);
        add(5,  16,   0, 1, 'h650, 0,  0, 0);   // clr wins over inc
        add(6,   0,   0, 1, 'hF10, 0,  0, 0);   // 29 rows of scroll
        add(1,   0,   0, 1, 'h600, 0,  0, 0);   // pending base wraps to 0

        for (int i = 0; i < vecs.size(); i++) begin
            run_probe(vecs[i].scr, vecs[i].line, vecs[i].pix);
            check($sformatf("vec%0d_valid", i), 32'(addr_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d_addr", i),  32'(char_addr),  32'(vecs[i].addr));
            check($sformatf("vec%0d_gx", i),    32'(glyph_x),    32'(vecs[i].gx));
            check($sformatf("vec%0d_gy", i),    32'(glyph_y),    32'(vecs[i].gy));
            check($sformatf("vec%0d_hit", i),   32'(cursor_hit), 32'(vecs[i].hit && CUR_EN));
        end

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
